// File: rtl/csa_accum_ctrl.sv
// csa_accum_ctrl: multi-operand carry-save accumulator controller.
// A row of N 5:3 compressor cells folds one operand pair per cycle into
// registered sum/carry vectors. On the last beat the redundant state is
// resolved by a carry-propagate add and offered on the result port.
//
// Optional feature macro: ACC_OVF_EN (adds o_res_ovf and sticky overflow
// tracking; when undefined the port and its logic do not exist).
//
// Handshake rule (both ports): a transfer happens on a rising edge where
// valid and ready are both 1. The operand port ignores i_in_a/i_in_b/
// i_in_last while o_in_ready is 0. i_flush wins over every transfer.
module csa_accum_ctrl #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_flush,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [N-1:0] i_in_a,
    input  logic [N-1:0] i_in_b,
    input  logic         i_in_last,
    output logic         o_res_valid,
    input  logic         i_res_ready,
    output logic [N-1:0] o_res_sum,
`ifdef ACC_OVF_EN
    output logic         o_res_ovf,
`endif
    output logic [1:0]   o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_OUT     = 2'd3
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [N-1:0] r_s;
    logic [N-1:0] r_c;
    logic [N-1:0] r_res_sum;

    logic         w_accept;
    logic [N-1:0] w_s_in;
    logic [N-1:0] w_c_in;
    logic [N-1:0] w_s1;
    logic [N-1:0] w_icout;
    logic [N-1:0] w_cin;
    logic [N-1:0] w_sum;
    logic [N-1:0] w_cout;

    // Ready only while collecting operands; a flushed beat is never accepted.
    assign o_in_ready  = (r_state == ST_IDLE) || (r_state == ST_ACCUM);
    assign o_res_valid = (r_state == ST_OUT);
    assign o_res_sum   = r_res_sum;
    assign o_dbg_state = r_state;
    assign w_accept    = i_in_valid && o_in_ready && !i_flush;

    // The first beat of a sum starts from zero instead of stale S/C.
    assign w_s_in = (r_state == ST_IDLE) ? '0 : r_s;
    assign w_c_in = (r_state == ST_IDLE) ? '0 : r_c;

    // Compressor row: first full adder on A,B,S' yields the lateral carry,
    // which depends only on local inputs, so the chain is one cell deep.
    assign w_s1    = i_in_a ^ i_in_b ^ w_s_in;
    assign w_icout = (i_in_a & i_in_b) | (i_in_a & w_s_in) | (i_in_b & w_s_in);
    assign w_cin   = {w_icout[N-2:0], 1'b0};
    assign w_sum   = w_s1 ^ w_c_in ^ w_cin;
    assign w_cout  = (w_s1 & w_c_in) | (w_s1 & w_cin) | (w_c_in & w_cin);

`ifdef ACC_OVF_EN
    logic [N:0]   w_cpa;
    logic         w_drop;
    logic         r_ovf_acc;
    logic         r_res_ovf;
    assign w_cpa     = {1'b0, r_s} + {1'b0, r_c};
    assign w_drop    = w_cout[N-1] | w_icout[N-1];
    assign o_res_ovf = r_res_ovf;

    // Sticky record of carries shifted out of the top column; restarts on
    // the first beat of each sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_acc <= 1'b0;
            r_res_ovf <= 1'b0;
        end else if (i_flush) begin
            r_ovf_acc <= 1'b0;
            r_res_ovf <= 1'b0;
        end else begin
            if (w_accept)
                r_ovf_acc <= (r_state == ST_IDLE) ? w_drop : (r_ovf_acc | w_drop);
            if (r_state == ST_RESOLVE)
                r_res_ovf <= r_ovf_acc | w_cpa[N];
        end
    end
`else
    logic [N-1:0] w_cpa;
    assign w_cpa = r_s + r_c;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic; flush returns to IDLE from anywhere.
    always_comb begin
        w_state_nxt = r_state;
        if (i_flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_ACCUM: begin
                    if (w_accept)
                        w_state_nxt = i_in_last ? ST_RESOLVE : ST_ACCUM;
                end
                ST_RESOLVE: w_state_nxt = ST_OUT;
                ST_OUT: begin
                    if (i_res_ready)
                        w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Carry-save state update and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s       <= '0;
            r_c       <= '0;
            r_res_sum <= '0;
        end else if (i_flush) begin
            r_s <= '0;
            r_c <= '0;
        end else begin
            if (w_accept) begin
                r_s <= w_sum;
                r_c <= {w_cout[N-2:0], 1'b0};
            end
            if (r_state == ST_RESOLVE)
                r_res_sum <= w_cpa[N-1:0];
        end
    end

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Directed bench for csa_accum_ctrl: a 32-bit and an 8-bit instance share
// the control inputs; operands are truncated for the narrow one.
module tb_csa_accum_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic in_valid;
  logic in_last;
  logic res_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;

  logic        in_ready32, res_valid32, ovf32;
  logic [31:0] sum32;
  logic [1:0]  state32;
  logic        in_ready8, res_valid8, ovf8;
  logic [7:0]  sum8;
  logic [1:0]  state8;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  csa_accum_ctrl #(.N(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .i_flush(flush),
    .i_in_valid(in_valid), .o_in_ready(in_ready32),
    .i_in_a(in_a), .i_in_b(in_b), .i_in_last(in_last),
    .o_res_valid(res_valid32), .i_res_ready(res_ready),
    .o_res_sum(sum32),
`ifdef ACC_OVF_EN
    .o_res_ovf(ovf32),
`endif
    .o_dbg_state(state32)
  );

  csa_accum_ctrl #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .i_flush(flush),
    .i_in_valid(in_valid), .o_in_ready(in_ready8),
    .i_in_a(in_a[7:0]), .i_in_b(in_b[7:0]), .i_in_last(in_last),
    .o_res_valid(res_valid8), .i_res_ready(res_ready),
    .o_res_sum(sum8),
`ifdef ACC_OVF_EN
    .o_res_ovf(ovf8),
`endif
    .o_dbg_state(state8)
  );

`ifndef ACC_OVF_EN
  assign ovf32 = 1'b0;
  assign ovf8  = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // driver: present one pair for exactly one edge
  task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic last);
    check("in_ready_at_beat", {in_ready32, in_ready8}, 2'b11);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // scoreboard: called right after the last beat was accepted
  task automatic expect_result(input logic exp_ovf32, input logic exp_ovf8);
    logic [31:0] exp;
    check("resolve_in_ready", {in_ready32, in_ready8}, 2'b00);
    check("resolve_res_valid", {res_valid32, res_valid8}, 2'b00);
    tick();
    check("out_res_valid", {res_valid32, res_valid8}, 2'b11);
    check("out_in_ready", {in_ready32, in_ready8}, 2'b00);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      exp = exp_q.pop_front();
      check("res_sum32", sum32, exp);
      check("res_sum8", sum8, exp[7:0]);
    end
`ifdef ACC_OVF_EN
    check("res_ovf32", ovf32, exp_ovf32);
    check("res_ovf8", ovf8, exp_ovf8);
`else
    if (exp_ovf32 || exp_ovf8) n_checks += 0;
`endif
  endtask

  task automatic take_result;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("after_hs_in_ready", {in_ready32, in_ready8}, 2'b11);
    check("after_hs_res_valid", {res_valid32, res_valid8}, 2'b00);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    res_ready = 1'b0; in_a = '0; in_b = '0;
    #2;
    check("reset_in_ready", {in_ready32, in_ready8}, 2'b11);
    check("reset_res_valid", {res_valid32, res_valid8}, 2'b00);
    check("reset_res_sum", {sum32, sum8}, 40'd0);
    check("reset_ovf", {ovf32, ovf8}, 2'b00);
    check("reset_state", {state32, state8}, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // single beat 3+5
    exp_q.push_back(32'd8);
    send_beat(32'd3, 32'd5, 1'b1);
    expect_result(1'b0, 1'b0);
    take_result();

    // four beats back-to-back, minimum gap after the previous handshake
    exp_q.push_back(32'd36);
    send_beat(32'd1, 32'd2, 1'b0);
    send_beat(32'd3, 32'd4, 1'b0);
    send_beat(32'd5, 32'd6, 1'b0);
    send_beat(32'd7, 32'd8, 1'b1);
    expect_result(1'b0, 1'b0);
    take_result();

    // wrap: 8-bit overflows to 0, 32-bit gives 256
    exp_q.push_back(32'd256);
    send_beat(32'd255, 32'd1, 1'b0);
    send_beat(32'd0, 32'd0, 1'b1);
    expect_result(1'b0, 1'b1);
    take_result();

    // no wrap: 200+50
    exp_q.push_back(32'd250);
    send_beat(32'd200, 32'd50, 1'b1);
    expect_result(1'b0, 1'b0);
    take_result();

    // both widths wrap
    exp_q.push_back(32'hFFFF_FFFE);
    send_beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    expect_result(1'b1, 1'b1);
    take_result();

    // backpressure: 11+22 held for 5 cycles
    exp_q.push_back(32'd33);
    send_beat(32'd11, 32'd22, 1'b1);
    expect_result(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_res_sum", {sum32, sum8}, {32'd33, 8'd33});
      check("bp_in_ready", {in_ready32, in_ready8}, 2'b00);
      check("bp_res_valid", {res_valid32, res_valid8}, 2'b11);
    end
    take_result();

    // flush after 2 of 3 beats; the third beat is presented with flush
    send_beat(32'd10, 32'd20, 1'b0);
    send_beat(32'd10, 32'd20, 1'b0);
    flush = 1'b1; in_valid = 1'b1; in_a = 32'd10; in_b = 32'd20; in_last = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    check("flush_state", {state32, state8}, 4'd0);
    check("flush_res_valid", {res_valid32, res_valid8}, 2'b00);
    tick();
    check("flush_no_result", {res_valid32, res_valid8, state32, state8}, 6'd0);
    exp_q.push_back(32'd16);
    send_beat(32'd7, 32'd9, 1'b1);
    expect_result(1'b0, 1'b0);
    take_result();

    // asynchronous reset in the middle of an accumulation
    send_beat(32'd40, 32'd2, 1'b0);
    send_beat(32'd1, 32'd1, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_in_ready", {in_ready32, in_ready8}, 2'b11);
    check("rst_mid_res_valid", {res_valid32, res_valid8}, 2'b00);
    check("rst_mid_res_sum", {sum32, sum8}, 40'd0);
    check("rst_mid_state", {state32, state8}, 4'd0);
    check("rst_mid_ovf", {ovf32, ovf8}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    exp_q.push_back(32'd123);
    send_beat(32'd100, 32'd23, 1'b1);
    expect_result(1'b0, 1'b0);
    take_result();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
